config_tx_mc: RTL
=================

// Module: config_tx_mc
// PURPOSE
//  Multi-channel successor of the serial configuration transmitter. Fetches config
//  words from a synchronous register file and shifts C_NO_CFG_BITS per channel out
//  on NUM_CH data lines sharing one TX_CLK. Frames repeat every LINE_PERIOD clocks
//  while START is high, or fire once per START rising edge. Sits between the config
//  register bank and the sensor/DAC serial pins.
// PARAMETERS
//  CLOCK_PERIOD_PS  20833  system clock period (48 MHz)
//  BIT_PERIOD_NS    400    target serial bit period
//  DATA_W           16     register word width
//  ADDR_W           3      register read address width
//  NUM_CH           1      parallel data lanes (1..8)
//  C_NO_CFG_BITS    24     bits per frame per lane; 1..(2**ADDR_W)*DATA_W
//  MSB_FIRST        1      1: word bit DATA_W-1 first; 0: bit 0 first
//  HALF_DIV (localparam) = max(1,(BIT_PERIOD_NS*1000+CLOCK_PERIOD_PS)/(2*CLOCK_PERIOD_PS)); 10 at defaults
// PORTS
//  CLOCK        in   1             system clock, all logic on rising edge
//  RESET_N      in   1             asynchronous active-low reset
//  START        in   1             level enable for frame generation
//  LINE_PERIOD  in   16            frame repeat period in clocks; 0 = one-shot mode
//  INPUT        in   NUM_CH*DATA_W read data, lane k in [k*DATA_W +: DATA_W]
//  RD_ADDR      out  ADDR_W        word index being fetched
//  RD_EN        out  1             read strobe, data valid on INPUT next cycle
//  TX_CLK       out  NUM_CH? no: 1 serial clock, common to all lanes
//  TX_DAT       out  NUM_CH        serial data per lane
//  TX_OE        out  1             output enable for TX_CLK/TX_DAT pads
//  TX_END       out  1             one-cycle pulse at end of each frame
//  BUSY         out  1             high from FETCH through END
// BEHAVIOUR
//  Reset (async, RESET_N=0): all outputs 0, state IDLE, counters 0. Reset mid-frame
//   aborts immediately; no TX_END issued.
//  States: IDLE -> FETCH -> LOAD -> SHIFT -> END -> GAP -> FETCH | IDLE.
//  IDLE: leave to FETCH when START=1 (LINE_PERIOD!=0) or on START 0->1 edge (LINE_PERIOD=0).
//  FETCH (1 clk): RD_EN=1, RD_ADDR=0; line counter cleared to 0 (frame start).
//  LOAD (1 clk): capture INPUT into shift regs of all lanes; TX_OE rises.
//  SHIFT: each bit = 2*HALF_DIV clocks; TX_CLK low first HALF_DIV, high second
//   HALF_DIV (receiver samples on rising edge); TX_DAT changes only at bit start.
//   Word w supplies frame bits w*DATA_W.. ; last word truncated to remaining bits,
//   taking its first-shifted bits per MSB_FIRST. Next word prefetched: RD_EN pulse
//   with RD_ADDR=w+1 on first clock of word w's last bit, captured next clock; no
//   gap between words. RD_ADDR holds last value between strobes.
//  END (1 clk): TX_END=1, TX_OE=0, TX_CLK=0, TX_DAT=0.
//  TX_DAT = 0 and TX_CLK = 0 whenever TX_OE = 0.
//  FRAME_LEN = 3 + C_NO_CFG_BITS*2*HALF_DIV clocks (483 at defaults).
//  GAP: next FETCH at line count = max(LINE_PERIOD, FRAME_LEN); LINE_PERIOD sampled at
//   FETCH. Go IDLE instead if START=0 or LINE_PERIOD=0 at that point.
//  START dropping mid-frame: frame completes with TX_END, then IDLE.
//  Line counter saturates at 16'hFFFF; never wraps.
// TESTING
//  T1 defaults, NUM_CH=1, words 0:A5C3 1:F00F, LINE_PERIOD=4000, START=1 -> TX_DAT
//     bits A5C3 then F0 MSB first, 20 clk/bit, TX_END 483 clk after FETCH, FETCH at 0,4000,8000.
//  T2 LINE_PERIOD=100 -> frames back-to-back, FETCH every 483 clocks, no overlap.
//  T3 LINE_PERIOD=0, START held high 20000 clks -> exactly one frame; drop/raise START
//     -> one more frame.
//  T4 RESET_N low during bit 10 -> all outputs 0 within same cycle, no TX_END; restart
//     after release gives full clean frame.
//  T5 NUM_CH=2, MSB_FIRST=0, lane1 words 0:1234 1:00FF -> lane1 bits 0x1234 LSB first
//     then 0xFF low byte; lanes share TX_CLK edges exactly.
//  T6 START low at bit 5 -> frame finishes, single TX_END, then IDLE, BUSY=0.

Source files
------------

// File: rtl/config_tx_mc.sv
// Multi-lane serial configuration transmitter: fetches words from a synchronous register
// file and shifts C_NO_CFG_BITS per lane out on a shared TX_CLK, one-shot or periodic.
module config_tx_mc #(
    parameter int unsigned CLOCK_PERIOD_PS = 20833,
    parameter int unsigned BIT_PERIOD_NS   = 400,
    parameter int unsigned DATA_W          = 16,
    parameter int unsigned ADDR_W          = 3,
    parameter int unsigned NUM_CH          = 1,
    parameter int unsigned C_NO_CFG_BITS   = 24,
    parameter bit          MSB_FIRST       = 1'b1
) (
    input  logic                     CLOCK,
    input  logic                     RESET_N,
    input  logic                     START,
    input  logic [15:0]              LINE_PERIOD,
    input  logic [NUM_CH*DATA_W-1:0] INPUT,
    output logic [ADDR_W-1:0]        RD_ADDR,
    output logic                     RD_EN,
    output logic                     TX_CLK,
    output logic [NUM_CH-1:0]        TX_DAT,
    output logic                     TX_OE,
    output logic                     TX_END,
    output logic                     BUSY
);

    localparam int unsigned HalfCalc = (BIT_PERIOD_NS * 1000 + CLOCK_PERIOD_PS) /
                                       (2 * CLOCK_PERIOD_PS);
    localparam int unsigned HalfDiv  = (HalfCalc < 1) ? 1 : HalfCalc;
    localparam int unsigned DivW     = $clog2(2 * HalfDiv);
    localparam int unsigned BitW     = (C_NO_CFG_BITS > 1) ? $clog2(C_NO_CFG_BITS) : 1;
    localparam int unsigned PosW     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned FrameLen = 3 + C_NO_CFG_BITS * 2 * HalfDiv;

    localparam logic [DivW-1:0] DivLast = DivW'(2 * HalfDiv - 1);
    localparam logic [DivW-1:0] DivHigh = DivW'(HalfDiv);
    localparam logic [BitW-1:0] BitLast = BitW'(C_NO_CFG_BITS - 1);
    localparam logic [PosW-1:0] PosLast = PosW'(DATA_W - 1);

    typedef enum logic [2:0] {StIdle, StFetch, StLoad, StShift, StEnd, StGap} state_e;

    state_e                         state_q, state_d;
    logic [15:0]                    line_q, line_d;
    logic [15:0]                    lp_q, lp_d;
    logic                           start_q;
    logic [DivW-1:0]                div_q, div_d;
    logic [BitW-1:0]                bit_q, bit_d;
    logic [PosW-1:0]                pos_q, pos_d;
    logic [ADDR_W-1:0]              word_q, word_d;
    logic [NUM_CH-1:0][DATA_W-1:0]  sr_q, sr_d, sr_shift;
    logic [NUM_CH-1:0][DATA_W-1:0]  nxt_q, nxt_d;
    logic                           cap_q;
    logic                           rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]              rd_addr_q, rd_addr_d;

    logic [31:0] target;
    logic        at_target;
    logic        bit_end;

    assign target    = (32'(lp_q) > FrameLen) ? 32'(lp_q) : FrameLen;
    // True on the last clock before the line counter reaches the repeat point.
    assign at_target = (32'(line_q) + 32'd1) >= target;
    assign bit_end   = (div_q == DivLast);

    always_comb begin
        sr_shift = '0;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            sr_shift[k] = MSB_FIRST ? (sr_q[k] << 1) : (sr_q[k] >> 1);
        end
    end

    always_comb begin
        state_d   = state_q;
        line_d    = (line_q == 16'hFFFF) ? line_q : line_q + 16'd1;
        lp_d      = lp_q;
        div_d     = div_q;
        bit_d     = bit_q;
        pos_d     = pos_q;
        word_d    = word_q;
        sr_d      = sr_q;
        nxt_d     = nxt_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;

        unique case (state_q)
            StIdle: begin
                line_d = '0;
                if ((LINE_PERIOD != 16'd0) ? START : (START && !start_q)) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                lp_d    = LINE_PERIOD;
                state_d = StLoad;
            end
            StLoad: begin
                sr_d    = INPUT;
                div_d   = '0;
                bit_d   = '0;
                pos_d   = '0;
                word_d  = '0;
                state_d = StShift;
            end
            StShift: begin
                div_d = div_q + 1'b1;
                if (cap_q) begin
                    nxt_d = INPUT;
                end
                if (bit_end) begin
                    div_d = '0;
                    if (bit_q == BitLast) begin
                        state_d = StEnd;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        if (pos_q == PosLast) begin
                            pos_d  = '0;
                            word_d = word_q + 1'b1;
                            // With a 2-clock bit the prefetched word lands on this very edge.
                            sr_d   = cap_q ? INPUT : nxt_q;
                        end else begin
                            pos_d = pos_q + 1'b1;
                            sr_d  = sr_shift;
                        end
                    end
                end
            end
            StEnd: begin
                if (!START || (lp_q == 16'd0)) begin
                    state_d = StIdle;
                end else if (at_target) begin
                    state_d = StFetch;
                end else begin
                    state_d = StGap;
                end
            end
            StGap: begin
                if (at_target) begin
                    state_d = START ? StFetch : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d == StFetch) begin
            line_d    = '0;
            rd_en_d   = 1'b1;
            rd_addr_d = '0;
        end else if ((state_d == StShift) && (div_d == '0) && (pos_d == PosLast) &&
                     (bit_d != BitLast)) begin
            // First clock of a word's last bit: fetch the following word.
            rd_en_d   = 1'b1;
            rd_addr_d = word_d + 1'b1;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= StIdle;
            line_q    <= '0;
            lp_q      <= '0;
            start_q   <= 1'b0;
            div_q     <= '0;
            bit_q     <= '0;
            pos_q     <= '0;
            word_q    <= '0;
            sr_q      <= '0;
            nxt_q     <= '0;
            cap_q     <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            line_q    <= line_d;
            lp_q      <= lp_d;
            start_q   <= START;
            div_q     <= div_d;
            bit_q     <= bit_d;
            pos_q     <= pos_d;
            word_q    <= word_d;
            sr_q      <= sr_d;
            nxt_q     <= nxt_d;
            cap_q     <= rd_en_q && (state_q == StShift);
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    always_comb begin
        TX_DAT = '0;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            TX_DAT[k] = (state_q == StShift) &&
                        (MSB_FIRST ? sr_q[k][DATA_W-1] : sr_q[k][0]);
        end
    end

    assign TX_CLK  = (state_q == StShift) && (div_q >= DivHigh);
    assign TX_OE   = state_q inside {StLoad, StShift};
    assign TX_END  = (state_q == StEnd);
    assign BUSY    = state_q inside {StFetch, StLoad, StShift, StEnd};
    assign RD_EN   = rd_en_q;
    assign RD_ADDR = rd_addr_q;

endmodule
